// File: rtl/regfile.sv
// ============================================================================
// Module   : regfile
// Purpose  : NUM_REGS x DATA_WIDTH register file, one write port, two
//            combinational read ports, register 0 hardwired to zero.
//            Optional macro REGFILE_BYPASS_EN forwards write data to readers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  ctrl_writeEnable,
    input  logic [4:0]            ctrl_writeReg,
    input  logic [4:0]            ctrl_readRegA,
    input  logic [4:0]            ctrl_readRegB,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB
);

    // Index 0 has no storage; it is synthesised as a constant zero.
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS-1:1];
    logic [DATA_WIDTH-1:0] w_rdata_a;
    logic [DATA_WIDTH-1:0] w_rdata_b;
    logic                  w_fwd_a;
    logic                  w_fwd_b;

    generate
        for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
            always_ff @(posedge clock or negedge ctrl_reset) begin
                if (!ctrl_reset) begin
                    r_regs[g] <= '0;
                end else if (ctrl_writeEnable && (ctrl_writeReg == 5'(g))) begin
                    r_regs[g] <= data_writeReg;
                end
            end
        end
    endgenerate

`ifdef REGFILE_BYPASS_EN
    assign w_fwd_a = ctrl_writeEnable && (ctrl_writeReg != 5'd0) &&
                     (ctrl_readRegA == ctrl_writeReg);
    assign w_fwd_b = ctrl_writeEnable && (ctrl_writeReg != 5'd0) &&
                     (ctrl_readRegB == ctrl_writeReg);
`else
    assign w_fwd_a = 1'b0;
    assign w_fwd_b = 1'b0;
`endif

    always_comb begin
        w_rdata_a = '0;
        w_rdata_b = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (ctrl_readRegA == 5'(i)) w_rdata_a = r_regs[i];
            if (ctrl_readRegB == 5'(i)) w_rdata_b = r_regs[i];
        end
    end

    // Reset gating sits last so a forwarded write can never leak out during reset.
    always_comb begin
        data_readRegA = w_fwd_a ? data_writeReg : w_rdata_a;
        data_readRegB = w_fwd_b ? data_writeReg : w_rdata_b;
        if (!ctrl_reset) begin
            data_readRegA = '0;
            data_readRegB = '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile.sv
// ============================================================================
// Module   : tb_regfile
// Purpose  : Scoreboard bench for regfile (honours REGFILE_BYPASS_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile;

    logic        clock;
    logic        ctrl_reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_writeReg;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;

    logic [31:0] model [32];
    logic [31:0] exp_q [$];
    logic [31:0] ea;
    logic [31:0] eb;
    int          vectors;
    int          errors;

    regfile #(.DATA_WIDTH(32), .NUM_REGS(32)) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_writeReg    (data_writeReg),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic do_write(input logic [4:0] r, input logic [31:0] d);
        @(negedge clock);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = r;
        data_writeReg    = d;
        @(posedge clock);
        #1;
        ctrl_writeEnable = 1'b0;
        if (r != 5'd0) model[r] = d;
    endtask

    task automatic test_reset();
        ctrl_reset = 1'b0;
        clear_model();
        // Write attempt while reset is held must be blocked.
        @(negedge clock);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd4;
        data_writeReg    = 32'hDEAD_BEEF;
        ctrl_readRegA    = 5'd4;
        ctrl_readRegB    = 5'd4;
        @(posedge clock);
        #1;
        exp_q.push_back(32'h0);
        ea = exp_q.pop_front();
        vectors++;
        if (data_readRegA !== ea || data_readRegB !== ea) begin
            errors++;
            $display("FAIL reset_blocked_write: A=%h B=%h expected %h", data_readRegA, data_readRegB, ea);
        end
        ctrl_writeEnable = 1'b0;
        @(negedge clock);
        ctrl_reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            ctrl_readRegA = 5'(i);
            ctrl_readRegB = 5'(31 - i);
            exp_q.push_back(model[i]);
            exp_q.push_back(model[31 - i]);
            #1;
            ea = exp_q.pop_front();
            eb = exp_q.pop_front();
            vectors++;
            if (data_readRegA !== ea || data_readRegB !== eb) begin
                errors++;
                $display("FAIL reset_state idx %0d: A=%h B=%h expected A=%h B=%h", i, data_readRegA, data_readRegB, ea, eb);
            end
        end
    endtask

    task automatic test_basic();
        do_write(5'd1, 32'h0000_0005);
        do_write(5'd31, 32'hFFFF_FFFF);
        @(negedge clock);
        ctrl_readRegA = 5'd1;
        ctrl_readRegB = 5'd31;
        exp_q.push_back(32'h0000_0005);
        exp_q.push_back(32'hFFFF_FFFF);
        #1;
        ea = exp_q.pop_front();
        eb = exp_q.pop_front();
        vectors++;
        if (data_readRegA !== ea || data_readRegB !== eb) begin
            errors++;
            $display("FAIL basic_write: A=%h B=%h expected A=%h B=%h", data_readRegA, data_readRegB, ea, eb);
        end
        for (int i = 2; i <= 30; i++) begin
            @(negedge clock);
            ctrl_readRegA = 5'(i);
            ctrl_readRegB = 5'(i);
            exp_q.push_back(32'h0);
            #1;
            ea = exp_q.pop_front();
            vectors++;
            if (data_readRegA !== ea || data_readRegB !== ea) begin
                errors++;
                $display("FAIL others_hold idx %0d: A=%h B=%h expected %h", i, data_readRegA, data_readRegB, ea);
            end
        end
    endtask

    task automatic test_r0();
        do_write(5'd0, 32'h1234_5678);
        @(negedge clock);
        ctrl_readRegA = 5'd0;
        ctrl_readRegB = 5'd0;
        exp_q.push_back(32'h0);
        #1;
        ea = exp_q.pop_front();
        vectors++;
        if (data_readRegA !== ea || data_readRegB !== ea) begin
            errors++;
            $display("FAIL r0_hardwired: A=%h B=%h expected %h", data_readRegA, data_readRegB, ea);
        end
    endtask

    task automatic test_read_during_write();
        do_write(5'd3, 32'h0000_0007);
        @(negedge clock);
        ctrl_readRegA    = 5'd3;
        ctrl_readRegB    = 5'd1;
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd3;
        data_writeReg    = 32'h0000_0009;
`ifdef REGFILE_BYPASS_EN
        exp_q.push_back(32'h0000_0009);
`else
        exp_q.push_back(32'h0000_0007);
`endif
        exp_q.push_back(model[1]);
        #1;
        ea = exp_q.pop_front();
        eb = exp_q.pop_front();
        vectors++;
        if (data_readRegA !== ea || data_readRegB !== eb) begin
            errors++;
            $display("FAIL rdw_before_edge: A=%h B=%h expected A=%h B=%h", data_readRegA, data_readRegB, ea, eb);
        end
        @(posedge clock);
        #1;
        ctrl_writeEnable = 1'b0;
        model[3] = 32'h0000_0009;
        exp_q.push_back(model[3]);
        #1;
        ea = exp_q.pop_front();
        vectors++;
        if (data_readRegA !== ea) begin
            errors++;
            $display("FAIL rdw_after_edge: A=%h expected %h", data_readRegA, ea);
        end
    endtask

    task automatic test_hold_and_reset();
        do_write(5'd10, 32'hA5A5_A5A5);
        @(negedge clock);
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'd10;
        data_writeReg    = 32'h0;
        ctrl_readRegA    = 5'd10;
        ctrl_readRegB    = 5'd3;
        @(posedge clock);
        #1;
        exp_q.push_back(32'hA5A5_A5A5);
        exp_q.push_back(model[3]);
        ea = exp_q.pop_front();
        eb = exp_q.pop_front();
        vectors++;
        if (data_readRegA !== ea || data_readRegB !== eb) begin
            errors++;
            $display("FAIL we_low_hold: A=%h B=%h expected A=%h B=%h", data_readRegA, data_readRegB, ea, eb);
        end
        // Mid-cycle asynchronous reset pulse
        #2;
        ctrl_reset = 1'b0;
        clear_model();
        #1;
        exp_q.push_back(32'h0);
        ea = exp_q.pop_front();
        vectors++;
        if (data_readRegA !== ea || data_readRegB !== ea) begin
            errors++;
            $display("FAIL async_reset_clear: A=%h B=%h expected %h", data_readRegA, data_readRegB, ea);
        end
        // Write held during reset loses; first edge after release writes
        ctrl_writeEnable = 1'b1;
        data_writeReg    = 32'h0BAD_F00D;
        @(posedge clock);
        #1;
        exp_q.push_back(32'h0);
        ea = exp_q.pop_front();
        vectors++;
        if (data_readRegA !== ea) begin
            errors++;
            $display("FAIL write_vs_reset: A=%h expected %h", data_readRegA, ea);
        end
        @(negedge clock);
        ctrl_reset = 1'b1;
        @(posedge clock);
        #1;
        ctrl_writeEnable = 1'b0;
        model[10] = 32'h0BAD_F00D;
        exp_q.push_back(model[10]);
        exp_q.push_back(model[3]);
        #1;
        ea = exp_q.pop_front();
        eb = exp_q.pop_front();
        vectors++;
        if (data_readRegA !== ea || data_readRegB !== eb) begin
            errors++;
            $display("FAIL first_write_after_reset: A=%h B=%h expected A=%h B=%h", data_readRegA, data_readRegB, ea, eb);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd5;
        data_writeReg    = 32'h5555_0005;
        @(negedge clock);
        ctrl_writeReg    = 5'd6;
        data_writeReg    = 32'h6666_0006;
        @(negedge clock);
        ctrl_writeReg    = 5'd7;
        data_writeReg    = 32'h7777_0007;
        @(negedge clock);
        ctrl_writeEnable = 1'b0;
        model[5] = 32'h5555_0005;
        model[6] = 32'h6666_0006;
        model[7] = 32'h7777_0007;
        for (int i = 5; i <= 7; i++) begin
            @(negedge clock);
            ctrl_readRegA = 5'(i);
            ctrl_readRegB = 5'(i);
            exp_q.push_back(model[i]);
            #1;
            ea = exp_q.pop_front();
            vectors++;
            if (data_readRegA !== ea || data_readRegB !== ea) begin
                errors++;
                $display("FAIL back_to_back idx %0d: A=%h B=%h expected %h", i, data_readRegA, data_readRegB, ea);
            end
        end
    endtask

    task automatic test_sweep();
        for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i));
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            ctrl_readRegA = 5'(i);
            ctrl_readRegB = 5'(31 - i);
            exp_q.push_back(32'(i));
            exp_q.push_back(32'(31 - i));
            #1;
            ea = exp_q.pop_front();
            eb = exp_q.pop_front();
            vectors++;
            if (data_readRegA !== ea || data_readRegB !== eb) begin
                errors++;
                $display("FAIL sweep idx %0d: A=%h B=%h expected A=%h B=%h", i, data_readRegA, data_readRegB, ea, eb);
            end
        end
    endtask

    initial begin
        vectors          = 0;
        errors           = 0;
        ctrl_reset       = 1'b0;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'd0;
        ctrl_readRegA    = 5'd0;
        ctrl_readRegB    = 5'd0;
        data_writeReg    = 32'h0;
        clear_model();
        test_reset();
        test_basic();
        test_r0();
        test_read_during_write();
        test_hold_and_reset();
        test_back_to_back();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of every register and data port.
REQ-002 Parameter: NUM_REGS, default 32, register count; select ports are 5 bits wide.
REQ-003 clock  input  1  single clock; all writes on its rising edge.
REQ-004 ctrl_reset  input  1  reset, asynchronous, active-low.
REQ-005 ctrl_writeEnable  input  1  write strobe, active-high.
REQ-006 ctrl_writeReg  input  5  write register index.
REQ-007 ctrl_readRegA  input  5  read port A register index.
REQ-008 ctrl_readRegB  input  5  read port B register index.
REQ-009 data_writeReg  input  DATA_WIDTH  write data.
REQ-010 data_readRegA  output  DATA_WIDTH  read port A data.
REQ-011 data_readRegB  output  DATA_WIDTH  read port B data.

Function
REQ-012 Storage SHALL be NUM_REGS registers of DATA_WIDTH bits, indices 0..31.
REQ-013 Write: on a rising clock edge with ctrl_writeEnable=1 and ctrl_reset=1, register[ctrl_writeReg] SHALL take data_writeReg.
REQ-014 A write SHALL modify only the addressed register; all others hold.
REQ-015 ctrl_writeEnable=0 SHALL leave all registers unchanged.
REQ-016 Register 0 SHALL be hardwired to zero: writes to index 0 are ignored, reads of index 0 return 0.
REQ-017 Reads SHALL be combinational: outputs follow select and storage changes within the same cycle, with no clock latency.
REQ-018 Ports A and B SHALL be independent; both may address the same register and return identical data.
REQ-019 Read-during-write to the same nonzero index SHALL return the old value until the edge, then the new value (unless REQ-026 applies).
REQ-020 X or Z on the select inputs is outside the contract; there is no out-of-range index because the full 5-bit space is used.

Reset
REQ-021 ctrl_reset=0 SHALL asynchronously clear all registers to 0, independent of clock.
REQ-022 While ctrl_reset=0, writes SHALL be blocked and both read ports SHALL return 0.
REQ-023 A write edge coinciding with reset assertion SHALL lose to reset, and the register SHALL read 0.
REQ-024 Deassertion SHALL be asynchronous; the first rising edge after deassertion with write enabled SHALL perform a normal write.
REQ-025 Reset asserted mid-operation SHALL discard all previously written contents.

Configuration
REQ-026 Macro REGFILE_BYPASS_EN, when defined: if ctrl_writeEnable=1, ctrl_writeReg≠0, and a read select equals ctrl_writeReg, that port SHALL output data_writeReg combinationally; index 0 is still forced to 0 and reset still forces 0.
REQ-027 Without REGFILE_BYPASS_EN, no forwarding path SHALL exist, and read behaviour SHALL be exactly REQ-019.

Verification
REQ-028 Reset low, then high; read all 32 indices on A and B -> every value is 0.
REQ-029 Write 0x0000_0005 to r1, then 0xFFFF_FFFF to r31; read A=1, B=31 -> 5 and 0xFFFF_FFFF; r2..r30 read 0.
REQ-030 Write 0x1234_5678 to r0; read A=0 -> 0.
REQ-031 Write 7 to r3, then write 9 to r3 with A=3 held before the edge -> A=7 (no bypass) or 9 (REGFILE_BYPASS_EN) before the edge; 9 after the edge in both builds.
REQ-032 Write 0xA5A5_A5A5 to r10, then write enable=0 with data 0 on the next edge -> r10 stays 0xA5A5_A5A5; an asynchronous reset pulse mid-cycle -> r10 reads 0 immediately.
REQ-033 Sweep: write index i to register i for i=1..31, then read A=i and B=31-i for all i -> values match (index 0 reads 0).
